pagerank_accum_engine: RTL and testbench
========================================

PAGERANK_ACCUM_ENGINE -- requirements
Module: pagerank_accum_engine

Interface
REQ-001 SHALL have parameter DATA_W, default 32, width of rank, out-degree, base and result words.
REQ-002 SHALL have parameter ADDR_W, default 16, width of node ids and edge-list addresses.
REQ-003 SHALL have parameter FRAC_W, default 16, fractional bits of the unsigned fixed-point rank format.
REQ-004 SHALL have parameter DAMP, default 55705 (0.85 in Q16.16), damping factor in the rank format.
REQ-005 SHALL have port clk  in  1  the single clock; all logic is rising-edge.
REQ-006 SHALL have port reset  in  1  asynchronous, active-low reset.
REQ-007 SHALL have port job_valid  in  1  job request present.
REQ-008 SHALL have port job_ready  out  1  engine idle and accepting a job.
REQ-009 SHALL have port job_node  in  ADDR_W  destination node id.
REQ-010 SHALL have port job_start  in  ADDR_W  first edge-list address (inclusive).
REQ-011 SHALL have port job_end  in  ADDR_W  last edge-list address (exclusive).
REQ-012 SHALL have port base_term  in  DATA_W  (1-d)/N term, sampled at job accept.
REQ-013 SHALL have port edge_en  out  1  edge-list BRAM read enable.
REQ-014 SHALL have port edge_addr  out  ADDR_W  edge-list BRAM address.
REQ-015 SHALL have port edge_rdata  in  ADDR_W  source node id, valid 1 cycle after edge_en.
REQ-016 SHALL have port node_en  out  1  rank/out-degree BRAM read enable (shared).
REQ-017 SHALL have port node_addr  out  ADDR_W  rank/out-degree BRAM address (shared).
REQ-018 SHALL have port rank_rdata  in  DATA_W  source rank, valid 1 cycle after node_en.
REQ-019 SHALL have port deg_rdata  in  DATA_W  source out-degree (integer), valid 1 cycle after node_en.
REQ-020 SHALL have port res_valid  out  1  result available.
REQ-021 SHALL have port res_ready  in  1  consumer accepts result.
REQ-022 SHALL have port res_node  out  ADDR_W  job_node of the result.
REQ-023 SHALL have port res_rank  out  DATA_W  new rank of res_node.
REQ-024 SHALL have port zero_deg_cnt  out  16  saturating count of edges whose source had out-degree 0.

Function
REQ-025 SHALL implement FSM IDLE, EDGE_RD, NODE_RD, LOAD, DIV, ACC, SCALE, OUT; job_ready=1 only in IDLE.
REQ-026 SHALL, on job_valid&&job_ready, latch job fields and base_term, clear sum, set ptr=job_start; go EDGE_RD, or SCALE if job_start>=job_end (empty job).
REQ-027 SHALL in EDGE_RD drive edge_en=1, edge_addr=ptr for one cycle; NODE_RD drives node_en=1, node_addr=edge_rdata for one cycle; LOAD latches rank_rdata and deg_rdata.
REQ-028 SHALL in LOAD route deg=0 to ACC with contribution 0 (zero_deg_cnt+1), deg=1 to ACC with contribution=rank, otherwise to DIV.
REQ-029 SHALL in DIV run a restoring divider, one quotient bit per cycle, exactly DATA_W cycles, contribution=floor(rank/deg).
REQ-030 SHALL in ACC add contribution to sum saturating at 2^DATA_W-1, increment ptr, go SCALE if ptr==job_end else EDGE_RD.
REQ-031 SHALL take per-edge latency DATA_W+4 cycles when deg>=2, 4 cycles when deg<=1.
REQ-032 SHALL in SCALE compute res_rank = base + ((DAMP*sum) >> FRAC_W) with a 2*DATA_W-bit product, saturating at 2^DATA_W-1, in one cycle.
REQ-033 SHALL in OUT hold res_valid=1 with stable res_node/res_rank until res_ready=1, then return to IDLE the next cycle.
REQ-034 SHALL, for an empty job accepted in cycle 0, assert res_valid in cycle 2.
REQ-035 SHALL drive edge_en and node_en low in every state other than EDGE_RD and NODE_RD respectively.
REQ-036 SHALL ignore job_valid outside IDLE and deassert res_valid in the cycle after the handshake.

Reset
REQ-037 SHALL, while reset=0, asynchronously force IDLE, job_ready=1 after release, res_valid=0, edge_en=0, node_en=0, all addresses, res_node, res_rank, sum and zero_deg_cnt to 0, discarding any job in flight.

Verification (DATA_W=32, FRAC_W=16, DAMP=55705)
REQ-038 SHALL cover empty job start=5,end=5,base=0x2666 accepted cycle 0 -> res_valid cycle 2, res_rank=0x0000_2666.
REQ-039 SHALL cover one edge, rank=0x0001_0000, deg=4, base=0x2666 -> contribution 0x4000, res_rank=0x0000_5CCC, edge phase 36 cycles.
REQ-040 SHALL cover one edge with deg=0 -> res_rank=base, zero_deg_cnt increments by 1, DIV never entered.
REQ-041 SHALL cover two edges rank=0xFFFF_FFFF, deg=1, base=0x2666 -> sum saturates 0xFFFF_FFFF, res_rank=0xD999_2665.
REQ-042 SHALL cover res_ready low 10 cycles in OUT -> res_valid, res_node, res_rank stable, job_ready=0 throughout.
REQ-043 SHALL cover reset=0 asserted mid-DIV -> all outputs 0 immediately; after release job_ready=1 and no res_valid until a new job completes.

Source files
------------

// File: rtl/pagerank_accum_engine.sv
// rtl/pagerank_accum_engine.sv - per-node PageRank accumulation over an edge list with damping and base term
module pagerank_accum_engine #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 16,
    parameter int FRAC_W = 16,
    parameter int DAMP   = 55705
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              job_valid,
    output logic              job_ready,
    input  logic [ADDR_W-1:0] job_node,
    input  logic [ADDR_W-1:0] job_start,
    input  logic [ADDR_W-1:0] job_end,
    input  logic [DATA_W-1:0] base_term,
    output logic              edge_en,
    output logic [ADDR_W-1:0] edge_addr,
    input  logic [ADDR_W-1:0] edge_rdata,
    output logic              node_en,
    output logic [ADDR_W-1:0] node_addr,
    input  logic [DATA_W-1:0] rank_rdata,
    input  logic [DATA_W-1:0] deg_rdata,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [ADDR_W-1:0] res_node,
    output logic [DATA_W-1:0] res_rank,
    output logic [15:0]       zero_deg_cnt
);

    typedef enum logic [2:0] {
        IDLE,
        EDGE_RD,
        NODE_RD,
        LOAD,
        DIV,
        ACC,
        SCALE,
        OUT
    } state_t;

    localparam int                CNT_W    = $clog2(DATA_W) + 1;
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DATA_W - 1);
    localparam logic [DATA_W-1:0] DAMP_V   = DATA_W'(DAMP);
    localparam logic [DATA_W-1:0] SAT      = '1;

    state_t              state;
    logic [ADDR_W-1:0]   node_q;
    logic [ADDR_W-1:0]   end_q;
    logic [ADDR_W-1:0]   ptr;
    logic [DATA_W-1:0]   base_q;
    logic [DATA_W-1:0]   sum;
    logic [DATA_W-1:0]   contrib;   // doubles as the divider's dividend/quotient shift register
    logic [DATA_W-1:0]   rem;
    logic [DATA_W-1:0]   deg_q;
    logic [CNT_W-1:0]    div_cnt;

    logic [DATA_W:0]     div_trial;
    logic                div_ge;
    logic [DATA_W-1:0]   rem_next;
    logic [DATA_W:0]     acc_full;
    logic [DATA_W-1:0]   sum_next;
    logic [2*DATA_W-1:0] prod;
    logic [2*DATA_W-1:0] scaled;
    logic [2*DATA_W:0]   total;
    logic [DATA_W-1:0]   res_next;
    logic [ADDR_W-1:0]   ptr_inc;

    // The node BRAM address is the edge BRAM output itself; that output is
    // already registered inside the BRAM, so no extra cycle is spent here.
    assign node_addr = node_en ? edge_rdata : '0;

    // Restoring-divider step, saturating accumulate and damped scaling datapath
    always_comb begin
        div_trial = {rem, contrib[DATA_W-1]};
        div_ge    = div_trial >= {1'b0, deg_q};
        rem_next  = div_ge ? DATA_W'(div_trial - {1'b0, deg_q}) : div_trial[DATA_W-1:0];

        acc_full  = {1'b0, sum} + {1'b0, contrib};
        sum_next  = acc_full[DATA_W] ? SAT : acc_full[DATA_W-1:0];

        prod      = {{DATA_W{1'b0}}, DAMP_V} * {{DATA_W{1'b0}}, sum};
        scaled    = prod >> FRAC_W;
        total     = {1'b0, scaled} + {{(DATA_W + 1){1'b0}}, base_q};
        res_next  = (|total[2*DATA_W:DATA_W]) ? SAT : total[DATA_W-1:0];

        ptr_inc   = ptr + ADDR_W'(1);
    end

    // Job sequencing FSM with registered handshake and BRAM enables
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= IDLE;
            job_ready    <= 1'b0;
            edge_en      <= 1'b0;
            edge_addr    <= '0;
            node_en      <= 1'b0;
            res_valid    <= 1'b0;
            res_node     <= '0;
            res_rank     <= '0;
            zero_deg_cnt <= '0;
            node_q       <= '0;
            end_q        <= '0;
            ptr          <= '0;
            base_q       <= '0;
            sum          <= '0;
            contrib      <= '0;
            rem          <= '0;
            deg_q        <= '0;
            div_cnt      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    job_ready <= 1'b1;
                    if (job_valid && job_ready) begin
                        job_ready <= 1'b0;
                        node_q    <= job_node;
                        end_q     <= job_end;
                        ptr       <= job_start;
                        base_q    <= base_term;
                        sum       <= '0;
                        if (job_start >= job_end) begin
                            state <= SCALE;
                        end else begin
                            state     <= EDGE_RD;
                            edge_en   <= 1'b1;
                            edge_addr <= job_start;
                        end
                    end
                end
                EDGE_RD: begin
                    edge_en <= 1'b0;
                    node_en <= 1'b1;
                    state   <= NODE_RD;
                end
                NODE_RD: begin
                    node_en <= 1'b0;
                    state   <= LOAD;
                end
                LOAD: begin
                    deg_q <= deg_rdata;
                    if (deg_rdata == '0) begin
                        // A dangling source contributes nothing; count it for software.
                        contrib <= '0;
                        if (zero_deg_cnt != 16'hFFFF) begin
                            zero_deg_cnt <= zero_deg_cnt + 16'd1;
                        end
                        state <= ACC;
                    end else if (deg_rdata == DATA_W'(1)) begin
                        contrib <= rank_rdata;
                        state   <= ACC;
                    end else begin
                        contrib <= rank_rdata;
                        rem     <= '0;
                        div_cnt <= '0;
                        state   <= DIV;
                    end
                end
                DIV: begin
                    rem     <= rem_next;
                    contrib <= {contrib[DATA_W-2:0], div_ge};
                    div_cnt <= div_cnt + CNT_W'(1);
                    if (div_cnt == CNT_LAST) begin
                        state <= ACC;
                    end
                end
                ACC: begin
                    sum <= sum_next;
                    ptr <= ptr_inc;
                    if (ptr_inc == end_q) begin
                        state <= SCALE;
                    end else begin
                        state     <= EDGE_RD;
                        edge_en   <= 1'b1;
                        edge_addr <= ptr_inc;
                    end
                end
                SCALE: begin
                    res_rank  <= res_next;
                    res_node  <= node_q;
                    res_valid <= 1'b1;
                    state     <= OUT;
                end
                OUT: begin
                    if (res_ready) begin
                        res_valid <= 1'b0;
                        job_ready <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pagerank_accum_engine.sv
// tb/tb_pagerank_accum_engine.sv - scoreboard bench for pagerank_accum_engine
module tb_pagerank_accum_engine;

    logic        clk;
    logic        reset;
    logic        job_valid;
    logic        job_ready;
    logic [15:0] job_node;
    logic [15:0] job_start;
    logic [15:0] job_end;
    logic [31:0] base_term;
    logic        edge_en;
    logic [15:0] edge_addr;
    logic [15:0] edge_rdata;
    logic        node_en;
    logic [15:0] node_addr;
    logic [31:0] rank_rdata;
    logic [31:0] deg_rdata;
    logic        res_valid;
    logic        res_ready;
    logic [15:0] res_node;
    logic [31:0] res_rank;
    logic [15:0] zero_deg_cnt;

    pagerank_accum_engine #(
        .DATA_W(32),
        .ADDR_W(16),
        .FRAC_W(16),
        .DAMP  (55705)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .job_valid   (job_valid),
        .job_ready   (job_ready),
        .job_node    (job_node),
        .job_start   (job_start),
        .job_end     (job_end),
        .base_term   (base_term),
        .edge_en     (edge_en),
        .edge_addr   (edge_addr),
        .edge_rdata  (edge_rdata),
        .node_en     (node_en),
        .node_addr   (node_addr),
        .rank_rdata  (rank_rdata),
        .deg_rdata   (deg_rdata),
        .res_valid   (res_valid),
        .res_ready   (res_ready),
        .res_node    (res_node),
        .res_rank    (res_rank),
        .zero_deg_cnt(zero_deg_cnt)
    );

    typedef struct {
        logic [15:0] node;
        logic [31:0] rank;
    } exp_t;

    exp_t        exp_q[$];
    int          checks = 0;
    int          errors = 0;
    logic [15:0] edge_mem[64];
    logic [31:0] rank_mem[64];
    logic [31:0] deg_mem[64];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous-read BRAM models
    always @(posedge clk) begin
        if (edge_en) edge_rdata <= edge_mem[edge_addr[5:0]];
        if (node_en) begin
            rank_rdata <= rank_mem[node_addr[5:0]];
            deg_rdata  <= deg_mem[node_addr[5:0]];
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Result monitor: pops the scoreboard on every accepted result
    always @(negedge clk) begin
        if (res_valid && res_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL sb_unexpected actual node=%0h rank=%0h required none", res_node, res_rank);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("sb_node", 64'(res_node), 64'(e.node));
                chk("sb_rank", 64'(res_rank), 64'(e.rank));
            end
        end
    end

    task automatic do_job(input logic [15:0] node, input logic [15:0] s, input logic [15:0] e,
                          input logic [31:0] base, input logic [31:0] exp_rank, input bit push);
        int n = 0;
        exp_t x;
        while (!job_ready && n < 100) begin
            @(posedge clk); #1; n++;
        end
        if (!job_ready) chk("job_ready_wait", 64'(job_ready), 64'd1);
        job_node  = node;
        job_start = s;
        job_end   = e;
        base_term = base;
        job_valid = 1'b1;
        if (push) begin
            x.node = node;
            x.rank = exp_rank;
            exp_q.push_back(x);
        end
        @(posedge clk); #1;
        job_valid = 1'b0;
    endtask

    task automatic wait_res(input string name, input int exp_lat);
        int lat = 1;
        while (!res_valid && lat < 300) begin
            @(posedge clk); #1; lat++;
        end
        if (!res_valid) chk({name, "_timeout"}, 64'(res_valid), 64'd1);
        chk({name, "_latency"}, 64'(lat), 64'(exp_lat));
    endtask

    task automatic finish_res(input string name);
        @(posedge clk); #1;
        chk({name, "_valid_drop"}, 64'(res_valid), 64'd0);
        chk({name, "_ready_back"}, 64'(job_ready), 64'd1);
    endtask

    initial begin
        int seen;
        reset      = 1'b0;
        job_valid  = 1'b0;
        job_node   = '0;
        job_start  = '0;
        job_end    = '0;
        base_term  = '0;
        res_ready  = 1'b1;
        edge_rdata = '0;
        rank_rdata = '0;
        deg_rdata  = '0;
        for (int i = 0; i < 64; i++) begin
            edge_mem[i] = '0;
            rank_mem[i] = '0;
            deg_mem[i]  = '0;
        end
        edge_mem[10] = 16'd3;  rank_mem[3] = 32'h0001_0000; deg_mem[3] = 32'd4;
        edge_mem[12] = 16'd4;  rank_mem[4] = 32'h0001_2345; deg_mem[4] = 32'd0;
        edge_mem[20] = 16'd5;  edge_mem[21] = 16'd5;
        rank_mem[5]  = 32'hFFFF_FFFF; deg_mem[5] = 32'd1;
        edge_mem[30] = 16'd6;  rank_mem[6] = 32'h0003_0000; deg_mem[6] = 32'd3;
        edge_mem[31] = 16'd7;  rank_mem[7] = 32'h0001_0001; deg_mem[7] = 32'd2;
        edge_mem[32] = 16'd8;  rank_mem[8] = 32'h0000_2000; deg_mem[8] = 32'd1;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_res_valid", 64'(res_valid), 64'd0);
        chk("rst_edge_en", 64'(edge_en), 64'd0);
        chk("rst_node_en", 64'(node_en), 64'd0);
        chk("rst_zero_deg", 64'(zero_deg_cnt), 64'd0);
        reset = 1'b1;
        @(posedge clk); #1;
        chk("rst_job_ready", 64'(job_ready), 64'd1);

        // Empty job: result two cycles after accept
        do_job(16'd1, 16'd5, 16'd5, 32'h2666, 32'h0000_2666, 1'b1);
        wait_res("empty", 2);
        finish_res("empty");

        // One edge, degree 4: 36-cycle edge phase
        do_job(16'd2, 16'd10, 16'd11, 32'h2666, 32'h0000_5CCC, 1'b1);
        wait_res("deg4", 38);
        finish_res("deg4");

        // Degree-0 source: no divide, counter increments
        do_job(16'd3, 16'd12, 16'd13, 32'h1111, 32'h0000_1111, 1'b1);
        wait_res("deg0", 6);
        chk("deg0_zero_cnt", 64'(zero_deg_cnt), 64'd1);
        finish_res("deg0");

        // Two saturating degree-1 edges
        do_job(16'd4, 16'd20, 16'd22, 32'h2666, 32'hD999_2665, 1'b1);
        wait_res("sat", 10);
        finish_res("sat");

        // Three mixed edges with consumer back-pressure for 10 cycles
        res_ready = 1'b0;
        do_job(16'd5, 16'd30, 16'd33, 32'h0100, 32'h0001_6298, 1'b1);
        wait_res("mixed", 78);
        job_node  = 16'h00EE;
        job_start = 16'd0;
        job_end   = 16'd0;
        job_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            chk("hold_valid", 64'(res_valid), 64'd1);
            chk("hold_node", 64'(res_node), 64'h5);
            chk("hold_rank", 64'(res_rank), 64'h0001_6298);
            chk("hold_job_ready", 64'(job_ready), 64'd0);
            @(posedge clk); #1;
        end
        job_valid = 1'b0;
        res_ready = 1'b1;
        finish_res("mixed");

        // Reset during the divide phase discards the job
        do_job(16'd6, 16'd10, 16'd11, 32'h2666, 32'h0, 1'b0);
        repeat (10) @(posedge clk);
        #1;
        reset = 1'b0;
        #1;
        chk("mid_rst_job_ready", 64'(job_ready), 64'd0);
        chk("mid_rst_edge_en", 64'(edge_en), 64'd0);
        chk("mid_rst_edge_addr", 64'(edge_addr), 64'd0);
        chk("mid_rst_node_en", 64'(node_en), 64'd0);
        chk("mid_rst_node_addr", 64'(node_addr), 64'd0);
        chk("mid_rst_res_valid", 64'(res_valid), 64'd0);
        chk("mid_rst_res_node", 64'(res_node), 64'd0);
        chk("mid_rst_res_rank", 64'(res_rank), 64'd0);
        chk("mid_rst_zero_deg", 64'(zero_deg_cnt), 64'd0);
        repeat (2) @(posedge clk);
        #2;
        reset = 1'b1;
        @(posedge clk); #1;
        chk("post_rst_job_ready", 64'(job_ready), 64'd1);
        seen = 0;
        for (int i = 0; i < 50; i++) begin
            if (res_valid) seen++;
            @(posedge clk); #1;
        end
        chk("post_rst_no_res", 64'(seen), 64'd0);

        // Fresh job after reset with start beyond end
        do_job(16'd9, 16'd8, 16'd3, 32'hABCD, 32'h0000_ABCD, 1'b1);
        wait_res("post_rst", 2);
        finish_res("post_rst");

        repeat (3) @(posedge clk);
        #1;
        chk("sb_drained", 64'(exp_q.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
